// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the exec_sequencer: instruction field layout,
// opcode values and FSM state encoding.
package exec_sequencer_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned REG_W   = 3;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS_MSB  = 8;
   localparam int unsigned RS_LSB  = 6;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'd1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'd2;
   localparam logic [OPC_W-1:0] OP_AND = 4'd3;
   localparam logic [OPC_W-1:0] OP_OR  = 4'd4;
   localparam logic [OPC_W-1:0] OP_XOR = 4'd5;
   localparam logic [OPC_W-1:0] OP_MOV = 4'd6;
   localparam logic [OPC_W-1:0] OP_LDI = 4'd7;
   localparam logic [OPC_W-1:0] OP_SHL = 4'd8;
   localparam logic [OPC_W-1:0] OP_SHR = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   // Opcodes that retire through WB with a register write.
   function automatic logic op_writes(input logic [OPC_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_SHR);
   endfunction

   function automatic logic op_illegal(input logic [OPC_W-1:0] op);
      return op > OP_SHR;
   endfunction

endpackage

// File: rtl/exec_sequencer_alu.sv
// Combinational 8-bit ALU used in the EXEC stage of exec_sequencer.
module alu8
   import exec_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   input  logic [OPC_W-1:0]  opcode,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              carry_we
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum      = '0;
      result   = '0;
      carry    = 1'b0;
      carry_we = 1'b0;
      case (opcode)
         OP_ADD: begin
            sum      = {1'b0, a} + {1'b0, b};
            result   = sum[DATA_W-1:0];
            carry    = sum[DATA_W];
            carry_we = 1'b1;
         end
         OP_SUB: begin
            result   = a - b;
            carry    = b > a;
            carry_we = 1'b1;
         end
         OP_AND: begin
            result   = a & b;
            carry_we = 1'b1;
         end
         OP_OR: begin
            result   = a | b;
            carry_we = 1'b1;
         end
         OP_XOR: begin
            result   = a ^ b;
            carry_we = 1'b1;
         end
         OP_MOV: result = b;
         OP_LDI: result = imm;
         OP_SHL: begin
            result   = {a[DATA_W-2:0], 1'b0};
            carry    = a[DATA_W-1];
            carry_we = 1'b1;
         end
         OP_SHR: begin
            result   = {1'b0, a[DATA_W-1:1]};
            carry    = a[0];
            carry_we = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// Four-phase instruction sequencer: accept, read register file, execute,
// write back. One instruction in flight, no queuing.
module exec_sequencer
   import exec_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic [REG_W-1:0]   rf_op1,
   output logic [REG_W-1:0]   rf_op2,
   input  logic [DATA_W-1:0]  rf_out1,
   input  logic [DATA_W-1:0]  rf_out2,
   output logic [DATA_W-1:0]  rf_data,
   output logic               rf_en_write,
   output logic               result_valid,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               illegal
);

   state_e             state_q;
   state_e             state_d;
   logic [INSTR_W-1:0] instr_q;
   logic               we_q;
   logic               rv_q;
   logic               accept;
   logic               retire;
   logic               flag_illegal;

   logic [OPC_W-1:0]   opc;
   logic [DATA_W-1:0]  alu_result;
   logic               alu_carry;
   logic               alu_carry_we;

   assign opc    = instr_q[OPC_MSB:OPC_LSB];
   assign rf_op1 = instr_q[RD_MSB:RD_LSB];
   assign rf_op2 = instr_q[RS_MSB:RS_LSB];

   // Reset gates the handshake and the write strobe immediately, so a reset
   // arriving in WB can never commit a register write on that edge.
   assign instr_ready  = (state_q == ST_IDLE) && rst_n;
   assign rf_en_write  = we_q && rst_n;
   assign result_valid = rv_q && rst_n;

   alu8 u_alu (
      .a        (rf_out1),
      .b        (rf_out2),
      .imm      (instr_q[IMM_MSB:IMM_LSB]),
      .opcode   (opc),
      .result   (alu_result),
      .carry    (alu_carry),
      .carry_we (alu_carry_we)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      retire       = 1'b0;
      flag_illegal = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               accept  = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: begin
            flag_illegal = op_illegal(opc);
            if (op_writes(opc)) begin
               retire  = 1'b1;
               state_d = ST_WB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and status registers; results land at the EXEC->WB edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q    <= '0;
         we_q       <= 1'b0;
         rv_q       <= 1'b0;
         rf_data    <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         we_q <= retire;
         rv_q <= retire;
         if (accept) instr_q <= instr;
         if (retire) begin
            rf_data   <= alu_result;
            zero_flag <= (alu_result == '0);
            if (alu_carry_we) carry_flag <= alu_carry;
         end
         if (flag_illegal) illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with a behavioural
// 8x8 register file attached to the read/write ports.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [2:0]  rf_op1;
   logic [2:0]  rf_op2;
   logic [7:0]  rf_out1;
   logic [7:0]  rf_out2;
   logic [7:0]  rf_data;
   logic        rf_en_write;
   logic        result_valid;
   logic        zero_flag;
   logic        carry_flag;
   logic        illegal;

   logic [7:0]  rf [8];
   logic        rf_init;
   int          writes = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   exec_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .rf_op1       (rf_op1),
      .rf_op2       (rf_op2),
      .rf_out1      (rf_out1),
      .rf_out2      (rf_out2),
      .rf_data      (rf_data),
      .rf_en_write  (rf_en_write),
      .result_valid (result_valid),
      .zero_flag    (zero_flag),
      .carry_flag   (carry_flag),
      .illegal      (illegal)
   );

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'h01;
      end else if (rf_en_write) begin
         rf[rf_op1] <= rf_data;
         writes     <= writes + 1;
      end
   end

   assign rf_out1 = rf[rf_op1];
   assign rf_out2 = rf[rf_op2];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one instruction and advance to the WB cycle (or IDLE if non-writing).
   task automatic issue(input logic [15:0] ins);
      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("read_ready", 16'(instr_ready), 16'd0);
      chk("read_we", 16'(rf_en_write), 16'd0);
      tick();
      chk("exec_we", 16'(rf_en_write), 16'd0);
      tick();
   endtask

   task automatic wb_check(input string tag, input logic [2:0] rd, input logic [7:0] data,
                           input logic z, input logic c);
      chk({tag, "_we"}, 16'(rf_en_write), 16'd1);
      chk({tag, "_rv"}, 16'(result_valid), 16'd1);
      chk({tag, "_op1"}, 16'(rf_op1), 16'(rd));
      chk({tag, "_data"}, 16'(rf_data), 16'(data));
      chk({tag, "_zero"}, 16'(zero_flag), 16'(z));
      chk({tag, "_carry"}, 16'(carry_flag), 16'(c));
      tick();
      chk({tag, "_we_off"}, 16'(rf_en_write), 16'd0);
      chk({tag, "_rv_off"}, 16'(result_valid), 16'd0);
      chk({tag, "_idle"}, 16'(instr_ready), 16'd1);
      chk({tag, "_rf"}, 16'(rf[rd]), 16'(data));
   endtask

   initial begin
      int acc;
      int w0;

      rst_n       = 1'b0;
      rf_init     = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      tick();
      tick();
      chk("rst_ready", 16'(instr_ready), 16'd0);
      chk("rst_op1", 16'(rf_op1), 16'd0);
      chk("rst_op2", 16'(rf_op2), 16'd0);
      chk("rst_data", 16'(rf_data), 16'd0);
      chk("rst_we", 16'(rf_en_write), 16'd0);
      chk("rst_flags", 16'({zero_flag, carry_flag, illegal, result_valid}), 16'd0);

      rst_n   = 1'b1;
      rf_init = 1'b0;
      #1;
      chk("rel_ready", 16'(instr_ready), 16'd1);
      tick();
      chk("rel_ready2", 16'(instr_ready), 16'd1);

      // ADD r2,r3 with all regs 0x01
      issue(16'h14C0);
      wb_check("add_r2r3", 3'd2, 8'h02, 1'b0, 1'b0);
      // LDI r5,0xFF then ADD r5,r1 wraps to zero with carry
      issue(16'h7AFF);
      wb_check("ldi_r5", 3'd5, 8'hFF, 1'b0, 1'b0);
      issue(16'h1A40);
      wb_check("add_r5r1", 3'd5, 8'h00, 1'b1, 1'b1);
      // MOV leaves carry untouched
      issue(16'h6D40);
      wb_check("mov_r6r5", 3'd6, 8'h00, 1'b1, 1'b1);
      issue(16'h7000);
      wb_check("ldi_r0", 3'd0, 8'h00, 1'b1, 1'b1);
      issue(16'h2040);
      wb_check("sub_r0r1", 3'd0, 8'hFF, 1'b0, 1'b1);
      issue(16'h3680);
      wb_check("and_r3r2", 3'd3, 8'h00, 1'b1, 1'b0);
      issue(16'h9800);
      wb_check("shr_r4", 3'd4, 8'h00, 1'b1, 1'b1);
      issue(16'h8400);
      wb_check("shl_r2", 3'd2, 8'h04, 1'b0, 1'b0);
      issue(16'h5440);
      wb_check("xor_r2r1", 3'd2, 8'h05, 1'b0, 1'b0);
      issue(16'h4680);
      wb_check("or_r3r2", 3'd3, 8'h05, 1'b0, 1'b0);

      // Illegal opcode returns straight to IDLE and sets the sticky flag
      w0 = writes;
      issue(16'hF000);
      chk("ill_flag", 16'(illegal), 16'd1);
      chk("ill_we", 16'(rf_en_write), 16'd0);
      chk("ill_rv", 16'(result_valid), 16'd0);
      chk("ill_idle", 16'(instr_ready), 16'd1);
      chk("ill_flags", 16'({zero_flag, carry_flag}), 16'd0);
      issue(16'h0000);
      chk("nop_idle", 16'(instr_ready), 16'd1);
      chk("nop_we", 16'(rf_en_write), 16'd0);
      chk("nop_writes", 16'(writes - w0), 16'd0);
      issue(16'h1240);
      wb_check("add_r1r1", 3'd1, 8'h02, 1'b0, 1'b0);
      chk("ill_sticky", 16'(illegal), 16'd1);

      // Valid held high: one accept per 4 cycles, the rest dropped
      acc = 0;
      w0  = writes;
      for (int i = 0; i < 12; i++) begin
         instr       = {4'h7, 3'd7, 1'b0, 8'(i)};
         instr_valid = 1'b1;
         if (instr_ready) acc++;
         tick();
      end
      instr_valid = 1'b0;
      chk("tput_accepts", 16'(acc), 16'd3);
      chk("tput_writes", 16'(writes - w0), 16'd3);
      chk("tput_r7", 16'(rf[7]), 16'h0008);
      chk("tput_idle", 16'(instr_ready), 16'd1);

      // Reset asserted during WB abandons the write
      w0 = writes;
      issue(16'h7C55);
      chk("wbrst_pre_we", 16'(rf_en_write), 16'd1);
      rst_n = 1'b0;
      #1;
      chk("wbrst_we_gated", 16'(rf_en_write), 16'd0);
      chk("wbrst_ready_low", 16'(instr_ready), 16'd0);
      tick();
      chk("wbrst_writes", 16'(writes - w0), 16'd0);
      chk("wbrst_r6", 16'(rf[6]), 16'h0000);
      chk("wbrst_outs", 16'({rf_op1, rf_op2, rf_data}), 16'd0);
      chk("wbrst_flags", 16'({rf_en_write, result_valid, zero_flag, carry_flag, illegal}), 16'd0);
      rst_n = 1'b1;
      #1;
      chk("wbrst_rel_ready", 16'(instr_ready), 16'd1);
      tick();
      chk("wbrst_rel_ready2", 16'(instr_ready), 16'd1);
      chk("wbrst_rel_we", 16'(rf_en_write), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
